sobel_column_filter: RTL and testbench

- Sobel stage between the grayscale FIFO and the sobel output FIFO in dut_system.
- Each cycle it pops one 3-pixel grayscale column (rows r-1, r, r+1) from a first-word-fall-through FIFO and keeps a 3x3 sliding window.
- It writes one 8-bit |Gx|+|Gy| magnitude per pixel, WIDTH outputs per row, to the sobel output FIFO.

---
 rtl/sobel_column_filter_pkg.sv | 19 +
 rtl/sobel_column_filter_if.sv | 27 ++
 rtl/sobel_column_filter_kernel.sv | 47 ++++
 rtl/sobel_column_filter.sv | 136 +++++++++++++
 tb/tb_sobel_column_filter.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/sobel_column_filter_pkg.sv
// sobel_pkg: shared widths, saturation limit and FSM state for the filter.
// Optional build macro used by the filter: SOBEL_ROW_BORDER_EN.
package sobel_pkg;

   localparam int PIX_W_DFLT = 8;
   localparam int GRAD_EXTRA = 3;
   localparam int GRAD_W     = PIX_W_DFLT + GRAD_EXTRA;
   localparam int SAT_MAX    = (1 << PIX_W_DFLT) - 1;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } state_e;

   function automatic int grad_w(input int pix_w);
      return pix_w + GRAD_EXTRA;
   endfunction

endpackage

// File: rtl/sobel_column_filter_if.sv
// FIFO-side signals of the sobel column filter.
// slave = filter side, master = FIFO/environment side.
interface sobel_column_filter_if
   import sobel_pkg::*;
#(
   parameter int PIX_W = PIX_W_DFLT
);

   logic [3*PIX_W-1:0] in_dout;
   logic               in_empty;
   logic               in_rd_en;
   logic [PIX_W-1:0]   out_din;
   logic               out_full;
   logic               out_wr_en;
   logic               frame_done;

   modport master (
      output in_dout, in_empty, out_full,
      input  in_rd_en, out_din, out_wr_en, frame_done
   );

   modport slave (
      input  in_dout, in_empty, out_full,
      output in_rd_en, out_din, out_wr_en, frame_done
   );

endinterface

// File: rtl/sobel_column_filter_kernel.sv
// sobel_kernel: combinational 3x3 Sobel, |Gx|+|Gy| saturated to PIX_W bits.
// Columns: col0 oldest, col2 newest; lane0 top row, lane2 bottom row.
module sobel_kernel
   import sobel_pkg::*;
#(
   parameter int PIX_W = PIX_W_DFLT
) (
   input  logic [3*PIX_W-1:0] col0_i,
   input  logic [3*PIX_W-1:0] col1_i,
   input  logic [3*PIX_W-1:0] col2_i,
   output logic [PIX_W-1:0]   mag_o
);

   localparam int GW = grad_w(PIX_W);

   typedef logic signed [GW-1:0] grad_t;

   function automatic grad_t px(
      input logic [3*PIX_W-1:0] col,
      input int                 lane
   );
      return grad_t'({{GRAD_EXTRA{1'b0}}, col[lane*PIX_W +: PIX_W]});
   endfunction

   grad_t         gx;
   grad_t         gy;
   logic [GW-1:0] ax;
   logic [GW-1:0] ay;
   logic [GW-1:0] sum;

   // The centre pixel carries no weight in either gradient.
   logic unused_center;
   assign unused_center = ^col1_i[2*PIX_W-1:PIX_W];

   // Gradients, absolute values and saturated magnitude.
   always_comb begin
      gx = (px(col2_i, 0) + (px(col2_i, 1) <<< 1) + px(col2_i, 2))
         - (px(col0_i, 0) + (px(col0_i, 1) <<< 1) + px(col0_i, 2));
      gy = (px(col0_i, 0) + (px(col1_i, 0) <<< 1) + px(col2_i, 0))
         - (px(col0_i, 2) + (px(col1_i, 2) <<< 1) + px(col2_i, 2));
      ax = gx[GW-1] ? -gx : gx;
      ay = gy[GW-1] ? -gy : gy;
      sum = ax + ay;
      mag_o = (sum[GW-1:PIX_W] != '0) ? {PIX_W{1'b1}} : sum[PIX_W-1:0];
   end

endmodule

// File: rtl/sobel_column_filter.sv
// sobel_column_filter: column-streaming 3x3 Sobel magnitude stage.
// Build macro SOBEL_ROW_BORDER_EN zeroes every output of the first/last row.
module sobel_column_filter
   import sobel_pkg::*;
#(
   parameter int WIDTH  = 720,
   parameter int HEIGHT = 540,
   parameter int PIX_W  = PIX_W_DFLT
) (
   input  logic                  clock,
   input  logic                  reset,
   sobel_column_filter_if.slave  bus
);

   localparam int CW = $clog2(WIDTH);
   localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
   localparam int LW = 3 * PIX_W;

   localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] COL_ONE  = CW'(1);
   localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

   state_e           state_q, state_d;
   logic [CW-1:0]    col_q, col_d;
   logic [RW-1:0]    row_q, row_d;
   logic [LW-1:0]    w1_q, w1_d;
   logic [LW-1:0]    w2_q, w2_d;
   logic             out_valid_q, out_valid_d;
   logic [PIX_W-1:0] out_data_q, out_data_d;
   logic             out_last_q, out_last_d;

   logic             stage_free;
   logic             pop;
   logic             write;
   logic             load;
   logic             zero_row;
   logic [PIX_W-1:0] mag;
   logic [PIX_W-1:0] load_val;

   sobel_kernel #(
      .PIX_W (PIX_W)
   ) u_kernel (
      .col0_i (w1_q),
      .col1_i (w2_q),
      .col2_i (bus.in_dout),
      .mag_o  (mag)
   );

   assign write      = out_valid_q & ~bus.out_full;
   assign stage_free = ~out_valid_q | ~bus.out_full;
   assign pop        = (state_q == RUN) & ~bus.in_empty & stage_free;

   assign bus.in_rd_en   = pop;
   assign bus.out_wr_en  = write;
   assign bus.out_din    = out_data_q;
   assign bus.frame_done = write & out_last_q;

`ifdef SOBEL_ROW_BORDER_EN
   assign zero_row = (row_q == '0) | (row_q == ROW_LAST);
`else
   assign zero_row = 1'b0;
`endif

   // Window shift, column/row stepping and output-register reload.
   always_comb begin
      state_d    = state_q;
      col_d      = col_q;
      row_d      = row_q;
      w1_d       = w1_q;
      w2_d       = w2_q;
      load       = 1'b0;
      load_val   = '0;
      out_last_d = out_last_q;
      unique case (state_q)
         RUN: begin
            if (pop) begin
               w1_d = w2_q;
               w2_d = bus.in_dout;
               if (col_q != '0) begin
                  load = 1'b1;
                  if (col_q != COL_ONE && !zero_row) begin
                     load_val = mag;
                  end
               end
               if (col_q == COL_LAST) begin
                  col_d   = '0;
                  state_d = FLUSH;
               end else begin
                  col_d = col_q + 1'b1;
               end
            end
         end
         FLUSH: begin
            if (stage_free) begin
               load    = 1'b1;
               state_d = RUN;
               if (row_q == ROW_LAST) begin
                  row_d = '0;
               end else begin
                  row_d = row_q + 1'b1;
               end
            end
         end
         default: ;
      endcase
      out_valid_d = load | (out_valid_q & ~write);
      out_data_d  = load ? load_val : out_data_q;
      if (load) begin
         out_last_d = (state_q == FLUSH) & (row_q == ROW_LAST);
      end
   end

   // State, window and output register; reset drops any partial row.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= RUN;
         col_q       <= '0;
         row_q       <= '0;
         w1_q        <= '0;
         w2_q        <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         row_q       <= row_d;
         w1_q        <= w1_d;
         w2_q        <= w2_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
      end
   end

endmodule

// File: tb/tb_sobel_column_filter.sv
// Self-checking bench for sobel_column_filter (WIDTH=8, HEIGHT=4).
// Frame-level Sobel model feeds an expected-output queue.
module tb_sobel_column_filter;

   localparam int W  = 8;
   localparam int H  = 4;
   localparam int PW = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   sobel_column_filter_if #(.PIX_W(PW)) bus ();

   sobel_column_filter #(
      .WIDTH  (W),
      .HEIGHT (H),
      .PIX_W  (PW)
   ) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_fail = 0;

   logic [3*PW-1:0] src [$];
   logic [PW:0]     exp_q [$];
   int              log_q [$];

   int   wr_cnt = 0;
   int   fd_cnt = 0;
   int   pop_cnt = 0;
   int   stall_pops = 0;
   logic rd_s = 1'b0;
   logic full_ctl = 1'b0;
   logic [PW:0] e_w;

   int vrow [8] = '{0, 0, 0, 0, 255, 255, 0, 0};
   int hrow [8] = '{0, 40, 40, 40, 40, 40, 40, 0};
   int vert [32];

   task automatic check(input string name, input int act, input int expv);
      n_cmp++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
      end
   endtask

   // pattern 0 flat, 1 vertical edge, 2 horizontal gradient
   function automatic int pix(input int pat, input int lane, input int c);
      case (pat)
         0: return 100;
         1: return (c < 5) ? 0 : 255;
         default: return (lane == 2) ? 20 : 10;
      endcase
   endfunction

   function automatic int mag(input int pat, input int c);
      int gx, gy, m;
      gx = (pix(pat, 0, c + 1) + 2 * pix(pat, 1, c + 1) + pix(pat, 2, c + 1))
         - (pix(pat, 0, c - 1) + 2 * pix(pat, 1, c - 1) + pix(pat, 2, c - 1));
      gy = (pix(pat, 0, c - 1) + 2 * pix(pat, 0, c) + pix(pat, 0, c + 1))
         - (pix(pat, 2, c - 1) + 2 * pix(pat, 2, c) + pix(pat, 2, c + 1));
      m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      return (m > 255) ? 255 : m;
   endfunction

   task automatic push_frame(input int pat);
      int v;
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            src.push_back({PW'(pix(pat, 2, c)), PW'(pix(pat, 1, c)),
                           PW'(pix(pat, 0, c))});
         end
         for (int c = 0; c < W; c++) begin
            v = (c == 0 || c == W - 1) ? 0 : mag(pat, c);
`ifdef SOBEL_ROW_BORDER_EN
            if (r == 0 || r == H - 1) v = 0;
`endif
            exp_q.push_back({(r == H - 1 && c == W - 1) ? 1'b1 : 1'b0, PW'(v)});
         end
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_writes(input int target, input int budget, input string name);
      int n;
      n = 0;
      while (wr_cnt < target && n < budget) begin
         cyc();
         n++;
      end
      repeat (6) cyc();
      check(name, wr_cnt, target);
   endtask

   // Upstream show-ahead FIFO and downstream full control.
   initial begin
      bus.in_empty = 1'b1;
      bus.in_dout  = '0;
      bus.out_full = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (rd_s && src.size() > 0) void'(src.pop_front());
         bus.out_full = full_ctl;
         bus.in_empty = (src.size() == 0);
         bus.in_dout  = (src.size() > 0) ? src[0] : '0;
      end
   end

   // Compare every write against the model queue.
   always @(negedge clk) begin
      rd_s = bus.in_rd_en;
      if (!rst) begin
         if (rd_s) pop_cnt++;
         if (bus.out_full && rd_s) stall_pops++;
         if (bus.out_full) check("no_write_when_full", int'(bus.out_wr_en), 0);
         if (bus.out_wr_en) begin
            wr_cnt++;
            log_q.push_back(int'(bus.out_din));
            if (bus.frame_done) fd_cnt++;
            if (exp_q.size() == 0) begin
               check("unexpected_write", 1, 0);
            end else begin
               e_w = exp_q.pop_front();
               check("out_din", int'(bus.out_din), int'(e_w[PW-1:0]));
               check("frame_done_on_write", int'(bus.frame_done), int'(e_w[PW]));
            end
         end else begin
            check("frame_done_idle", int'(bus.frame_done), 0);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, lb, fd0, n, p0;
      cyc();
      cyc();
      @(negedge clk);
      check("reset_in_rd_en", int'(bus.in_rd_en), 0);
      check("reset_out_wr_en", int'(bus.out_wr_en), 0);
      check("reset_out_din", int'(bus.out_din), 0);
      check("reset_frame_done", int'(bus.frame_done), 0);
      cyc();
      rst = 1'b0;

      // flat field
      base = wr_cnt;
      fd0 = fd_cnt;
      push_frame(0);
      wait_writes(base + 32, 400, "flat_writes");
      check("flat_frame_done_count", fd_cnt - fd0, 1);
      check("flat_drained", exp_q.size(), 0);

      // vertical edge
      base = wr_cnt;
      lb = log_q.size();
      push_frame(1);
      wait_writes(base + 32, 400, "vert_writes");
      for (int i = 0; i < 8; i++) check("vert_row1_literal", log_q[lb + 8 + i], vrow[i]);
      for (int i = 0; i < 32; i++) vert[i] = log_q[lb + i];

      // horizontal gradient
      base = wr_cnt;
      lb = log_q.size();
      push_frame(2);
      wait_writes(base + 32, 400, "horiz_writes");
      for (int i = 0; i < 8; i++) check("horiz_row1_literal", log_q[lb + 8 + i], hrow[i]);

      // backpressure in the middle of row 1
      base = wr_cnt;
      lb = log_q.size();
      push_frame(1);
      n = 0;
      while (wr_cnt < base + 11 && n < 200) begin
         cyc();
         n++;
      end
      check("stall_reached", int'(wr_cnt >= base + 11), 1);
      stall_pops = 0;
      full_ctl = 1'b1;
      repeat (5) cyc();
      full_ctl = 1'b0;
      check("stall_pops_le1", int'(stall_pops <= 1), 1);
      wait_writes(base + 32, 400, "stall_writes");
      for (int i = 0; i < 32; i++) check("stall_vs_unstalled", log_q[lb + i], vert[i]);

      // reset in row 1, then a fresh frame
      p0 = pop_cnt;
      push_frame(2);
      n = 0;
      while (pop_cnt < p0 + 12 && n < 200) begin
         cyc();
         n++;
      end
      check("reset_point_reached", int'(pop_cnt >= p0 + 12), 1);
      rst = 1'b1;
      src.delete();
      exp_q.delete();
      cyc();
      cyc();
      rst = 1'b0;
      base = wr_cnt;
      repeat (5) cyc();
      check("no_stale_write", wr_cnt - base, 0);
      lb = log_q.size();
      fd0 = fd_cnt;
      push_frame(1);
      wait_writes(base + 32, 400, "post_reset_writes");
      check("post_reset_first_value", log_q[lb], 0);
      check("post_reset_frame_done", fd_cnt - fd0, 1);
      check("post_reset_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
